mvm_stream: RTL and testbench

Next-generation matrix-vector multiply engine. The following are all parametrised:
- element width
- elements per memory word
- output lane count
- memory depths

---
 rtl/mvm_stream_pkg.sv | 13 +
 rtl/mvm_stream_dot_lanes.sv | 59 +++++
 rtl/mvm_stream.sv | 219 +++++++++++++++++++++
 tb/tb_mvm_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_stream_pkg.sv
// Shared types and constants for the mvm_stream matrix-vector engine.
package mvm_stream_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, STALL, DRAIN} state_t;

    // Pipeline stages from word issue to the accumulator update.
    localparam int PIPE_LAT = 4;

    function automatic int dot_sum_w(input int iwidth, input int lanes);
        return 2 * iwidth + $clog2(lanes);
    endfunction

endpackage

// File: rtl/mvm_stream_dot_lanes.sv
// One output lane's datapath: registered element-wise multiply, then a registered sum (2-cycle latency).
module dot_lanes
    import mvm_stream_pkg::*;
#(
    parameter int IWIDTH    = 8,
    parameter int DOT_LANES = 8,
    localparam int DATAW    = IWIDTH * DOT_LANES,
    localparam int PRODW    = 2 * IWIDTH,
    localparam int SUMW     = dot_sum_w(IWIDTH, DOT_LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signed_i,
    input  logic [DATAW-1:0] a_i,
    input  logic [DATAW-1:0] b_i,
    output logic [SUMW-1:0]  sum_o
);

    logic [PRODW-1:0] prod_q [DOT_LANES];
    logic             sgn_q;
    logic [SUMW-1:0]  sum_d;
    logic [SUMW-1:0]  sum_q;

    generate
        for (genvar gi = 0; gi < DOT_LANES; gi++) begin : g_mul
            logic [PRODW-1:0] a_ext;
            logic [PRODW-1:0] b_ext;
            logic [PRODW-1:0] prod;
            // Widening both operands first makes the truncated product exact in either mode.
            assign a_ext = {{IWIDTH{signed_i & a_i[gi*IWIDTH+IWIDTH-1]}}, a_i[gi*IWIDTH +: IWIDTH]};
            assign b_ext = {{IWIDTH{signed_i & b_i[gi*IWIDTH+IWIDTH-1]}}, b_i[gi*IWIDTH +: IWIDTH]};
            assign prod  = a_ext * b_ext;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) prod_q[gi] <= '0;
                else      prod_q[gi] <= prod;
            end
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < DOT_LANES; i++)
            sum_d = sum_d + (sgn_q ? SUMW'($signed(prod_q[i])) : SUMW'(prod_q[i]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn_q <= 1'b0;
            sum_q <= '0;
        end else begin
            sgn_q <= signed_i;
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mvm_stream.sv
// Streaming matrix-vector multiply with credit-guarded result FIFO.
// Optional MVM_STREAM_RELU_EN adds i_relu, clamping negative-MSB lanes to 0 at FIFO write.
module mvm_stream
    import mvm_stream_pkg::*;
#(
    parameter int IWIDTH        = 8,
    parameter int DOT_LANES     = 8,
    parameter int OWIDTH        = 32,
    parameter int NUM_OLANES    = 8,
    parameter int VEC_MEM_DEPTH = 256,
    parameter int MAT_MEM_DEPTH = 512,
    parameter int OFIFO_DEPTH   = 4,
    localparam int MEM_DATAW    = IWIDTH * DOT_LANES,
    localparam int VEC_ADDRW    = $clog2(VEC_MEM_DEPTH),
    localparam int MAT_ADDRW    = $clog2(MAT_MEM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MEM_DATAW-1:0]         i_vec_wdata,
    input  logic [VEC_ADDRW-1:0]         i_vec_waddr,
    input  logic                         i_vec_wen,
    input  logic [MEM_DATAW-1:0]         i_mat_wdata,
    input  logic [MAT_ADDRW-1:0]         i_mat_waddr,
    input  logic [NUM_OLANES-1:0]        i_mat_wen,
    input  logic                         i_start,
    input  logic                         i_signed,
`ifdef MVM_STREAM_RELU_EN
    input  logic                         i_relu,
`endif
    input  logic [VEC_ADDRW-1:0]         i_vec_start_addr,
    input  logic [VEC_ADDRW:0]           i_vec_num_words,
    input  logic [MAT_ADDRW-1:0]         i_mat_start_addr,
    input  logic [MAT_ADDRW:0]           i_mat_num_rows,
    output logic                         o_busy,
    output logic [NUM_OLANES*OWIDTH-1:0] o_result,
    output logic                         o_valid,
    input  logic                         i_ready
);

    localparam int SUMW  = dot_sum_w(IWIDTH, DOT_LANES);
    localparam int FPTRW = $clog2(OFIFO_DEPTH);
    localparam int CNTW  = FPTRW + 1;
    localparam int RESW  = NUM_OLANES * OWIDTH;
    localparam logic [VEC_ADDRW-1:0] VEC_LAST = VEC_ADDRW'(VEC_MEM_DEPTH - 1);
    localparam logic [MAT_ADDRW-1:0] MAT_LAST = MAT_ADDRW'(MAT_MEM_DEPTH - 1);

    state_t               state_q;
    logic                 signed_q;
`ifdef MVM_STREAM_RELU_EN
    logic                 relu_q;
`endif
    logic [VEC_ADDRW-1:0] vec_start_q;
    logic [VEC_ADDRW:0]   num_words_q;
    logic [MAT_ADDRW:0]   num_rows_q;
    logic [VEC_ADDRW:0]   w_q;
    logic [MAT_ADDRW:0]   r_q;
    logic [VEC_ADDRW-1:0] vaddr_q;
    logic [MAT_ADDRW-1:0] maddr_q;

    logic [PIPE_LAT-2:0]  vld_q, first_q, last_q;
    logic                 push_q;

    logic [RESW-1:0]      fifo_q [OFIFO_DEPTH];
    logic [FPTRW-1:0]     wptr_q, rptr_q;
    logic [CNTW-1:0]      occ_q, inflight_q;
    logic [CNTW:0]        credits;
    logic                 credits_full, issue_en, row_start, pop;
    logic [VEC_ADDRW:0]   w_last;
    logic [MAT_ADDRW:0]   r_last;
    logic [RESW-1:0]      push_data;

    logic [MEM_DATAW-1:0] vec_mem [VEC_MEM_DEPTH];
    logic [MEM_DATAW-1:0] vec_rdata_q;

    // Credits count results already queued plus rows that will be queued; a row only starts with a free credit.
    assign credits      = {1'b0, occ_q} + {1'b0, inflight_q};
    assign credits_full = (credits >= (CNTW+1)'(OFIFO_DEPTH));
    assign issue_en     = (state_q == ISSUE) && !((w_q == '0) && credits_full);
    assign row_start    = issue_en && (w_q == '0);
    assign w_last       = num_words_q - (VEC_ADDRW+1)'(1);
    assign r_last       = num_rows_q - (MAT_ADDRW+1)'(1);
    assign pop          = (occ_q != '0) && i_ready;

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (occ_q != '0);
    assign o_result = fifo_q[rptr_q];

    always_ff @(posedge clk) begin
        if (i_vec_wen) vec_mem[i_vec_waddr] <= i_vec_wdata;
        vec_rdata_q <= vec_mem[vaddr_q];
    end

    generate
        for (genvar gi = 0; gi < NUM_OLANES; gi++) begin : g_lane
            logic [MEM_DATAW-1:0] mat_mem [MAT_MEM_DEPTH];
            logic [MEM_DATAW-1:0] mat_rdata_q;
            logic [SUMW-1:0]      sum_w;
            logic [OWIDTH-1:0]    sum_ext;
            logic [OWIDTH-1:0]    acc_q;

            always_ff @(posedge clk) begin
                if (i_mat_wen[gi]) mat_mem[i_mat_waddr] <= i_mat_wdata;
                mat_rdata_q <= mat_mem[maddr_q];
            end

            dot_lanes #(
                .IWIDTH    (IWIDTH),
                .DOT_LANES (DOT_LANES)
            ) u_dot (
                .clk      (clk),
                .rst      (rst),
                .signed_i (signed_q),
                .a_i      (vec_rdata_q),
                .b_i      (mat_rdata_q),
                .sum_o    (sum_w)
            );

            assign sum_ext = signed_q ? OWIDTH'($signed(sum_w)) : OWIDTH'(sum_w);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    acc_q <= '0;
                else if (vld_q[PIPE_LAT-2])
                    acc_q <= first_q[PIPE_LAT-2] ? sum_ext : acc_q + sum_ext;
            end

`ifdef MVM_STREAM_RELU_EN
            assign push_data[gi*OWIDTH +: OWIDTH] = (relu_q && acc_q[OWIDTH-1]) ? '0 : acc_q;
`else
            assign push_data[gi*OWIDTH +: OWIDTH] = acc_q;
`endif
        end
    endgenerate

    // Word flags ride alongside the data so the accumulator knows where rows begin and end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            push_q  <= 1'b0;
        end else begin
            vld_q   <= {vld_q[PIPE_LAT-3:0], issue_en};
            first_q <= {first_q[PIPE_LAT-3:0], (w_q == '0)};
            last_q  <= {last_q[PIPE_LAT-3:0], (w_q == w_last)};
            push_q  <= vld_q[PIPE_LAT-2] & last_q[PIPE_LAT-2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OFIFO_DEPTH; i++) fifo_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
        end else begin
            if (push_q) begin
                fifo_q[wptr_q] <= push_data;
                wptr_q         <= wptr_q + FPTRW'(1);
            end
            if (pop) rptr_q <= rptr_q + FPTRW'(1);
            occ_q      <= occ_q + CNTW'(push_q) - CNTW'(pop);
            inflight_q <= inflight_q + CNTW'(row_start) - CNTW'(push_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            signed_q    <= 1'b0;
`ifdef MVM_STREAM_RELU_EN
            relu_q      <= 1'b0;
`endif
            vec_start_q <= '0;
            num_words_q <= '0;
            num_rows_q  <= '0;
            w_q         <= '0;
            r_q         <= '0;
            vaddr_q     <= '0;
            maddr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    signed_q    <= i_signed;
`ifdef MVM_STREAM_RELU_EN
                    relu_q      <= i_relu;
`endif
                    vec_start_q <= i_vec_start_addr;
                    num_words_q <= i_vec_num_words;
                    num_rows_q  <= i_mat_num_rows;
                    w_q         <= '0;
                    r_q         <= '0;
                    vaddr_q     <= i_vec_start_addr;
                    maddr_q     <= i_mat_start_addr;
                    state_q     <= (i_vec_num_words == '0 || i_mat_num_rows == '0) ? DRAIN : ISSUE;
                end
                ISSUE: if (!issue_en) begin
                    state_q <= STALL;
                end else begin
                    maddr_q <= (maddr_q == MAT_LAST) ? '0 : maddr_q + MAT_ADDRW'(1);
                    if (w_q == w_last) begin
                        w_q     <= '0;
                        vaddr_q <= vec_start_q;
                        if (r_q == r_last) state_q <= DRAIN;
                        else               r_q     <= r_q + (MAT_ADDRW+1)'(1);
                    end else begin
                        w_q     <= w_q + (VEC_ADDRW+1)'(1);
                        vaddr_q <= (vaddr_q == VEC_LAST) ? '0 : vaddr_q + VEC_ADDRW'(1);
                    end
                end
                STALL: if (!credits_full) state_q <= ISSUE;
                DRAIN: if (inflight_q == '0) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_stream.sv
// Directed bench for mvm_stream: a memory model computes expected rows into a scoreboard, a monitor pops on each handshake.
module tb_mvm_stream;

    localparam int IW = 8, DL = 8, OW = 32, NL = 8, VD = 256, MD = 512, FD = 4;
    localparam int DW = IW * DL, VAW = 8, MAW = 9, RW = NL * OW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   i_vec_wdata = '0;
    logic [VAW-1:0]  i_vec_waddr = '0;
    logic            i_vec_wen = 1'b0;
    logic [DW-1:0]   i_mat_wdata = '0;
    logic [MAW-1:0]  i_mat_waddr = '0;
    logic [NL-1:0]   i_mat_wen = '0;
    logic            i_start = 1'b0;
    logic            i_signed = 1'b0;
`ifdef MVM_STREAM_RELU_EN
    logic            i_relu = 1'b0;
`endif
    logic [VAW-1:0]  i_vec_start_addr = '0;
    logic [VAW:0]    i_vec_num_words = '0;
    logic [MAW-1:0]  i_mat_start_addr = '0;
    logic [MAW:0]    i_mat_num_rows = '0;
    logic            o_busy;
    logic [RW-1:0]   o_result;
    logic            o_valid;
    logic            i_ready = 1'b1;

    int tests = 0, fails = 0, pops = 0;
    logic [RW-1:0] sb[$];
    logic [RW-1:0] last_res = '0;
    logic [DW-1:0] vm [VD];
    logic [DW-1:0] mm [NL][MD];

    mvm_stream dut (
        .clk(clk), .rst(rst),
        .i_vec_wdata(i_vec_wdata), .i_vec_waddr(i_vec_waddr), .i_vec_wen(i_vec_wen),
        .i_mat_wdata(i_mat_wdata), .i_mat_waddr(i_mat_waddr), .i_mat_wen(i_mat_wen),
        .i_start(i_start), .i_signed(i_signed),
`ifdef MVM_STREAM_RELU_EN
        .i_relu(i_relu),
`endif
        .i_vec_start_addr(i_vec_start_addr), .i_vec_num_words(i_vec_num_words),
        .i_mat_start_addr(i_mat_start_addr), .i_mat_num_rows(i_mat_num_rows),
        .o_busy(o_busy), .o_result(o_result), .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_result: observed %h expected none", o_result);
            end else begin
                check("result", o_result, sb.pop_front());
            end
            last_res = o_result;
            pops++;
        end
    end

    function automatic longint elem(input logic [DW-1:0] wd, input int e, input logic sgn);
        logic [IW-1:0] x;
        x = wd[e*IW +: IW];
        return sgn ? longint'($signed(x)) : longint'({1'b0, x});
    endfunction

    function automatic logic [RW-1:0] exp_row(input logic sgn, input logic relu,
                                              input int vs, input int w, input int ms, input int r);
        logic [RW-1:0] res;
        longint        acc;
        logic [OW-1:0] v;
        int            va, ma;
        res = '0;
        for (int k = 0; k < NL; k++) begin
            acc = 0;
            for (int ww = 0; ww < w; ww++) begin
                va = (vs + ww) % VD;
                ma = (ms + r * w + ww) % MD;
                for (int e = 0; e < DL; e++)
                    acc += elem(vm[va], e, sgn) * elem(mm[k][ma], e, sgn);
            end
            v = acc[OW-1:0];
            if (relu && v[OW-1]) v = '0;
            res[k*OW +: OW] = v;
        end
        return res;
    endfunction

    task automatic wr_vec(input int a, input logic [DW-1:0] d);
        i_vec_waddr = VAW'(a); i_vec_wdata = d; i_vec_wen = 1'b1;
        vm[a] = d;
        @(posedge clk); #1 i_vec_wen = 1'b0;
    endtask

    task automatic wr_mat(input int a, input logic [NL-1:0] mask, input logic [DW-1:0] d);
        i_mat_waddr = MAW'(a); i_mat_wdata = d; i_mat_wen = mask;
        for (int k = 0; k < NL; k++) if (mask[k]) mm[k][a] = d;
        @(posedge clk); #1 i_mat_wen = '0;
    endtask

    task automatic fill_rand(input int vs, input int nv, input int ms, input int nm);
        logic [NL-1:0] mask;
        for (int a = 0; a < nv; a++) wr_vec((vs + a) % VD, {$urandom(), $urandom()});
        for (int k = 0; k < NL; k++) begin
            mask = '0; mask[k] = 1'b1;
            for (int a = 0; a < nm; a++) wr_mat((ms + a) % MD, mask, {$urandom(), $urandom()});
        end
    endtask

    task automatic start_job(input logic sgn, input logic relu, input int vs, input int w,
                             input int ms, input int r, input bit expect_out);
        logic eff_relu;
`ifdef MVM_STREAM_RELU_EN
        i_relu = relu;
        eff_relu = relu;
`else
        eff_relu = 1'b0;
`endif
        if (expect_out)
            for (int rr = 0; rr < r; rr++) sb.push_back(exp_row(sgn, eff_relu, vs, w, ms, rr));
        i_signed = sgn;
        i_vec_start_addr = VAW'(vs); i_vec_num_words = (VAW+1)'(w);
        i_mat_start_addr = MAW'(ms); i_mat_num_rows = (MAW+1)'(r);
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!o_busy && !o_valid && sb.size() == 0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check({tag, "_timeout"}, RW'(!ok), '0);
    endtask

    initial begin
        int n, p0;
        bit seen;
        logic [RW-1:0] neg64, zero_v;
        neg64 = {NL{32'hFFFF_FFC0}};
        zero_v = '0;

        #3;
        check("rst_busy", RW'(o_busy), '0);
        check("rst_valid", RW'(o_valid), '0);
        check("rst_result", o_result, '0);
        @(posedge clk); #1 rst = 1'b1;

        // Unsigned ones, W=1 R=1, with start-to-valid latency
        wr_vec(0, {DL{8'h01}});
        wr_mat(0, '1, {DL{8'h01}});
        start_job(1'b0, 1'b0, 0, 1, 0, 1, 1'b1);
        n = 1;
        for (int i = 0; i < 50 && !o_valid; i++) begin @(posedge clk); #1; n++; end
        check("valid_latency", RW'(n), RW'(6));
        wait_done("ones");
        check("ones_lanes", last_res, {NL{32'd8}});

        // Signed -1 x 2, W=4 R=2
        for (int a = 4; a < 8; a++) wr_vec(a, {DL{8'hFF}});
        for (int a = 8; a < 16; a++) wr_mat(a, '1, {DL{8'h02}});
        p0 = pops;
        start_job(1'b1, 1'b0, 4, 4, 8, 2, 1'b1);
        wait_done("signed");
        check("signed_count", RW'(pops - p0), RW'(2));
        check("signed_lanes", last_res, neg64);

        // Backpressure: R=10 with i_ready low stalls on credits
        fill_rand(10, 1, 20, 10);
        i_ready = 1'b0;
        p0 = pops;
        start_job(1'b0, 1'b0, 10, 1, 20, 10, 1'b1);
        repeat (60) begin @(posedge clk); #1; end
        check("bp_busy", RW'(o_busy), RW'(1));
        check("bp_valid", RW'(o_valid), RW'(1));
        i_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        i_ready = 1'b0;
        check("bp_four_popped", RW'(pops - p0), RW'(4));
        check("bp_fifo_empty", RW'(o_valid), '0);
        i_ready = 1'b1;
        wait_done("bp");
        check("bp_total", RW'(pops - p0), RW'(10));

        // Matrix address wrap 510,511,0,1
        fill_rand(12, 2, 510, 4);
        start_job(1'b1, 1'b0, 12, 2, 510, 2, 1'b1);
        wait_done("wrap");

        // W=0: one busy cycle, no output
        start_job(1'b0, 1'b0, 0, 0, 0, 3, 1'b0);
        check("w0_busy_first", RW'(o_busy), RW'(1));
        @(posedge clk); #1;
        check("w0_busy_after", RW'(o_busy), '0);
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (o_valid) seen = 1; end
        check("w0_no_valid", RW'(seen), '0);

        // Start pulse mid-job is ignored
        fill_rand(14, 2, 40, 6);
        start_job(1'b1, 1'b0, 14, 2, 40, 3, 1'b1);
        @(posedge clk); #1;
        i_vec_start_addr = '0; i_vec_num_words = (VAW+1)'(1);
        i_mat_start_addr = '0; i_mat_num_rows = (MAW+1)'(1);
        i_signed = 1'b0; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        check("ignored_busy", RW'(o_busy), RW'(1));
        wait_done("ignored");

        // Reset during ISSUE abandons the job
        start_job(1'b0, 1'b0, 32, 8, 64, 4, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("midrst_busy", RW'(o_busy), '0);
        check("midrst_valid", RW'(o_valid), '0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        start_job(1'b1, 1'b0, 4, 4, 8, 2, 1'b1);
        wait_done("after_rst");
        check("after_rst_lanes", last_res, neg64);

        // ReLU on the signed -64 case (pass-through when the feature is absent)
        start_job(1'b1, 1'b1, 4, 4, 8, 2, 1'b1);
        wait_done("relu");
`ifdef MVM_STREAM_RELU_EN
        check("relu_lanes", last_res, zero_v);
`else
        check("relu_lanes", last_res, neg64);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
